// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped port controller.
// Register offsets are word indices taken from Address[3:2].
package mmio_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0040;

  localparam logic [1:0] OFF_OUT    = 2'd0;
  localparam logic [1:0] OFF_IN     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_COUNT  = 2'd3;

  localparam int STAT_CHANGE = 0;
  localparam int STAT_IRQ_EN = 1;

  typedef struct packed {
    logic       hit;
    logic       rd;
    logic       wr;
    logic [1:0] sel;
  } mmioReq_t;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// accept_pulse is high in the cycle before stable takes a new value.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] portIn,
  output logic [7:0] stable,
  output logic       accept_pulse
);

  localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] candidate;
  logic [7:0] cnt;
  logic       settled;

  assign settled      = (sync2 == candidate) && (cnt == LIMIT);
  assign accept_pulse = settled && (stable != candidate);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      candidate <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else begin
      sync1 <= portIn;
      sync2 <= sync1;
      if (sync2 != candidate) begin
        candidate <= sync2;
        cnt       <= '0;
      end else if (cnt < LIMIT) begin
        cnt <= cnt + 8'd1;
      end
      if (accept_pulse) stable <= candidate;
    end
  end

endmodule

// File: rtl/mmio_port_controller.sv
// MMIO window beside DataMemory: output latch, debounced input,
// sticky change flag, event counter and interrupt line.
module mmio_port_controller
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = DEF_BASE_ADDR,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          COUNT_WIDTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        IOHit,
  output logic [31:0] PortOut,
  output logic        ChangeIRQ
);

  mmioReq_t               req;
  logic [7:0]             stable;
  logic                   accept;
  logic                   change;
  logic                   irqEn;
  logic [COUNT_WIDTH-1:0] eventCount;
  logic                   wrOut;
  logic                   wrStatus;
  logic                   wrCount;
  logic [1:0]             unusedAddr;

  assign unusedAddr = Address[1:0];

  assign req.hit = Address[31:4] == BASE_ADDR[31:4];
  assign req.rd  = req.hit & MemRead;
  assign req.wr  = req.hit & MemWrite;
  assign req.sel = Address[3:2];

  assign IOHit = req.hit;

  assign wrOut    = req.wr && (req.sel == OFF_OUT);
  assign wrStatus = req.wr && (req.sel == OFF_STATUS);
  assign wrCount  = req.wr && (req.sel == OFF_COUNT);

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk         (clk),
    .reset       (reset),
    .portIn      (PortIn),
    .stable      (stable),
    .accept_pulse(accept)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut    <= '0;
      change     <= 1'b0;
      irqEn      <= 1'b0;
      eventCount <= '0;
    end else begin
      if (wrOut) PortOut <= WriteData;
      if (wrStatus) irqEn <= WriteData[STAT_IRQ_EN];
      // A new accept outranks a same-edge W1C so no event is lost.
      if (accept) begin
        change <= 1'b1;
      end else if (wrStatus && WriteData[STAT_CHANGE]) begin
        change <= 1'b0;
      end
      if (wrCount) begin
        eventCount <= COUNT_WIDTH'(accept);
      end else begin
        eventCount <= eventCount + COUNT_WIDTH'(accept);
      end
    end
  end

  always_comb begin
    ReadData = '0;
    if (req.rd) begin
      unique case (1'b1)
        req.sel == OFF_OUT:    ReadData = PortOut;
        req.sel == OFF_IN:     ReadData = {24'b0, stable};
        req.sel == OFF_STATUS: ReadData = {30'b0, irqEn, change};
        req.sel == OFF_COUNT:  ReadData = 32'(eventCount);
      endcase
    end
  end

  assign ChangeIRQ = change & irqEn;

endmodule
